// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the multicycle EX-stage ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLTU = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Shares the hi/lo shift register, operand register and counter between both modes.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic             div_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign last = (cnt == CW'(1));

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, opnd};
        shifted = {acc, lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd});
        // When ge holds the difference is below the divisor, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - opnd;
        if (div_mode) begin
            hi_next = ge ? diff : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], ge};
        end else if (lo[0]) begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end else begin
            hi_next = {1'b0, acc[WIDTH-1:1]};
            lo_next = {acc[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt      <= '0;
            div_mode <= 1'b0;
            acc      <= '0;
            lo       <= '0;
            opnd     <= '0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            div_mode <= div;
            acc      <= '0;
            lo       <= div ? a : b;
            opnd     <= div ? b : a;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            acc <= hi_next;
            lo  <= lo_next;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle ops complete in one edge, MULU/DIVU
// iterate for WIDTH cycles behind a start/busy/done handshake.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             negative
);

    localparam int SHW = $clog2(WIDTH);

    state_t state, state_next;

    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] dif_ab;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             div_zero;
    logic             accept;
    logic             single;
    logic             iter_start;
    logic             iter_last;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    assign sum_ab   = A + B;
    assign dif_ab   = A - B;
    assign sh       = B[SHW-1:0];
    assign div_zero = (ALUOp == OP_DIVU) && (B == '0);
    assign accept   = (state == S_IDLE) && start;
    // Divide by zero bypasses the iterator and completes like a single-cycle op.
    assign single   = accept && (!is_multicycle(ALUOp) || div_zero);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                alu_res = sum_ab;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ab[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_ab;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ab[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SRL:  alu_res = A >> sh;
            OP_SLL:  alu_res = A << sh;
            OP_OR:   alu_res = A | B;
            OP_AND:  alu_res = A & B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SRA:  alu_res = $signed(A) >>> sh;
            OP_NOR:  alu_res = ~(A | B);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        iter_start = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_multicycle(ALUOp) && !div_zero) begin
                    iter_start = 1'b1;
                    state_next = (ALUOp == OP_DIVU) ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (iter_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .CLK     (CLK),
        .Reset   (Reset),
        .start   (iter_start),
        .div     (ALUOp == OP_DIVU),
        .a       (A),
        .b       (B),
        .last    (iter_last),
        .lo_next (iter_lo),
        .hi_next (iter_hi)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            done     <= 1'b0;
            result   <= '0;
            hi       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            if (single) begin
                done     <= 1'b1;
                result   <= div_zero ? '1 : alu_res;
                hi       <= div_zero ? A : '0;
                zero     <= div_zero ? 1'b0 : (alu_res == '0);
                negative <= div_zero ? 1'b1 : alu_res[WIDTH-1];
                overflow <= div_zero ? 1'b0 : alu_ovf;
            end else if (busy && iter_last) begin
                done     <= 1'b1;
                result   <= iter_lo;
                hi       <= iter_hi;
                zero     <= (iter_lo == '0);
                negative <= iter_lo[WIDTH-1];
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle (WIDTH=32) with hand-computed expectations.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        CLK;
    logic        Reset;
    logic        start;
    logic [3:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        overflow;
    logic        negative;

    int vectors = 0;
    int miscompares = 0;

    alu_multicycle #(
        .WIDTH(32)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .start    (start),
        .ALUOp    (ALUOp),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .overflow (overflow),
        .negative (negative)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge of the cycle after the start edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        ALUOp = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Counts cycles from the start edge until done; optionally pokes a stray start mid-run.
    task automatic wait_done(input bit poke, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            if (poke && lat == 10) begin
                ALUOp = OP_ADD;
                A     = 32'd3;
                B     = 32'd4;
                start = 1'b1;
            end
            if (lat == 11) start = 1'b0;
            if (poke && lat == 16) chk("mid_run_result_hold", result, 32'hFFFF_FFFF);
            @(negedge CLK);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;

        Reset = 1'b1;
        start = 1'b0;
        ALUOp = 4'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge CLK);
        chk("reset_result", result, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        Reset = 1'b0;

        // Leave non-zero outputs so the reset clear is observable.
        issue(OP_DIVU, 32'd100, 32'd0);
        chk("pre_divz_result", result, 32'hFFFF_FFFF);

        // Reset in the middle of a MULU run.
        issue(OP_MULU, 32'd5, 32'd6);
        chk("mul_busy_early", {31'b0, busy}, 32'h1);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_hi", hi, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge CLK);
        end
        chk("abort_no_done", pulses, 0);

        issue(OP_ADD, 32'd1, 32'd1);
        chk("add_1_1_done", {31'b0, done}, 32'h1);
        chk("add_1_1_result", result, 32'd2);

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        chk("add_ovf_done", {31'b0, done}, 32'h1);
        chk("add_ovf_result", result, 32'h8000_0000);
        chk("add_ovf_flags", {29'b0, zero, overflow, negative}, 32'b011);

        issue(OP_SUB, 32'd5, 32'd5);
        chk("sub_result", result, 32'h0);
        chk("sub_flags", {29'b0, zero, overflow, negative}, 32'b100);

        issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        chk("slt_result", result, 32'h1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
        chk("sltu_result", result, 32'h0);
        issue(OP_SRA, 32'h8000_0000, 32'h24);
        chk("sra_result", result, 32'hF800_0000);
        issue(OP_SRL, 32'h8000_0000, 32'h24);
        chk("srl_result", result, 32'h0800_0000);
        issue(OP_SLL, 32'h1, 32'h21);
        chk("sll_result", result, 32'h2);
        issue(OP_XOR, 32'hF0F0_1234, 32'h0FF0_1230);
        chk("xor_result", result, 32'hFF00_0004);
        issue(4'b1101, 32'h1234, 32'h5678);
        chk("rsvd_result", result, 32'h0);
        chk("rsvd_zero", {31'b0, zero}, 32'h1);
        issue(OP_NOR, 32'h0, 32'h0);
        chk("nor_result", result, 32'hFFFF_FFFF);
        chk("nor_hi", hi, 32'h0);

        issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b1, lat, bcnt);
        chk("mulu_latency", lat, 33);
        chk("mulu_busy_cycles", bcnt, 32);
        chk("mulu_result", result, 32'h0000_0001);
        chk("mulu_hi", hi, 32'hFFFF_FFFE);
        chk("mulu_flags", {29'b0, zero, overflow, negative}, 32'b000);
        @(negedge CLK);
        chk("mulu_done_once", {31'b0, done}, 32'h0);
        chk("mulu_stray_ignored", result, 32'h0000_0001);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(1'b0, lat, bcnt);
        chk("divu_latency", lat, 33);
        chk("divu_result", result, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(OP_DIVU, 32'd100, 32'd0);
        chk("divz_done", {31'b0, done}, 32'h1);
        chk("divz_busy", {31'b0, busy}, 32'h0);
        chk("divz_result", result, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'd100);
        chk("divz_flags", {29'b0, zero, overflow, negative}, 32'b001);

        // Back-to-back: ADD issued in the DIVU done cycle.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        wait_done(1'b0, lat, bcnt);
        chk("b2b_div_latency", lat, 33);
        chk("b2b_div_result", result, 32'h0FFF_FFFF);
        chk("b2b_div_hi", hi, 32'hF);
        ALUOp = OP_ADD;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("b2b_add_done", {31'b0, done}, 32'h1);
        chk("b2b_add_result", result, 32'd7);
        chk("b2b_add_hi", hi, 32'h0);
        @(negedge CLK);
        chk("b2b_add_done_once", {31'b0, done}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
